// File: rtl/reg_bank_reader_pkg.sv
// Shared definitions for the register-bank serial reader: FSM encoding,
// default bank geometry and the bit-counter sizing rule.
package reg_bank_reader_pkg;

    localparam int DEFAULT_NUM_REGS = 4;
    localparam int DEFAULT_WIDTH    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must be able to represent WIDTH itself, not just WIDTH-1.
    function automatic int count_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/reg_bank_reader_piso_shifter.sv
// Parallel-in serial-out shifter: load, shift right with zero fill, or hold.
// Carries its own bit counter, cleared on every load.
module piso_shifter
    import reg_bank_reader_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = count_bits(WIDTH)
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             lsb,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    count_reg;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            shreg_reg <= '0;
            count_reg <= '0;
        end else if (load) begin
            shreg_reg <= load_data;
            count_reg <= '0;
        end else if (shift_en) begin
            shreg_reg <= shreg_reg >> 1;
            count_reg <= count_reg + CW'(1);
        end
    end

    assign lsb   = shreg_reg[0];
    assign count = count_reg;

endmodule

// File: rtl/reg_bank_reader.sv
// Reads one register of a flattened bank on request, snapshots it to pdata
// and streams it LSB first on sdata/sframe, then pulses done for one cycle.
module reg_bank_reader
    import reg_bank_reader_pkg::*;
#(
    parameter  int NUM_REGS = DEFAULT_NUM_REGS,
    parameter  int WIDTH    = DEFAULT_WIDTH,
    localparam int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int CW       = count_bits(WIDTH)
) (
    input  logic                      CLK,
    input  logic                      CLR_N,
    input  logic [NUM_REGS*WIDTH-1:0] regs,
    input  logic                      req,
    input  logic [AW-1:0]             addr,
    input  logic                      hold,
    output logic                      busy,
    output logic                      sdata,
    output logic                      sframe,
    output logic [WIDTH-1:0]          pdata,
    output logic                      done
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] bank [NUM_REGS];
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] pdata_reg;
    logic             load;
    logic             shift_en;
    logic             shift_lsb;
    logic [CW-1:0]    bit_count;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
            assign bank[gi] = regs[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Indices past the bank (only possible when NUM_REGS is not a power of two) read zero.
    always_comb begin
        sel_data = '0;
        if (int'(addr) < NUM_REGS) begin
            sel_data = bank[addr];
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_reg <= ST_IDLE;
            pdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                pdata_reg <= sel_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b0;
        sframe     = 1'b0;
        sdata      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy   = 1'b1;
                sframe = 1'b1;
                sdata  = shift_lsb;
                if (!hold) begin
                    shift_en = 1'b1;
                    if (bit_count == LAST_BIT) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign pdata = pdata_reg;

    piso_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .CLK      (CLK),
        .CLR_N    (CLR_N),
        .load     (load),
        .load_data(sel_data),
        .shift_en (shift_en),
        .lsb      (shift_lsb),
        .count    (bit_count)
    );

endmodule
